// File: rtl/sr_instr_encoder.sv
// Symbolic-to-RV32I instruction encoder that streams encoded words into instruction memory.
// Optional build macro SR_ENC_HALT_EN appends a beq zero,zero,0 self-loop after the last word.
module sr_instr_encoder #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [19:0]   in_imm,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic          err_overflow
);

`ifdef SR_ENC_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_I      = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_BR     = 7'b1100011;
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_fin;
  logic          r_done;
  logic          r_err_illegal;
  logic          r_err_overflow;

  logic [31:0]   w_enc;
  logic          w_legal;
  logic          w_xfer;
  logic          w_at_end;

  assign in_ready     = (r_state == S_RUN);
  assign w_xfer       = in_valid & in_ready;
  assign w_at_end     = (r_ptr == PTR_LAST);
  assign im_we        = r_we;
  assign im_addr      = r_addr;
  assign im_wdata     = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign count        = r_count;
  assign err_illegal  = r_err_illegal;
  assign err_overflow = r_err_overflow;

  // Branch offsets must be even; an odd one is treated like an illegal op.
  always_comb begin
    w_enc   = 32'd0;
    w_legal = 1'b1;
    case (in_op)
      4'd0: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd1: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
      4'd2: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, OPC_R};
      4'd3: w_enc = {7'b0000000, in_rs2, in_rs1, 3'b011, in_rd, OPC_R};
      4'd4: w_enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd5: w_enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
      4'd6: w_enc = {in_imm[19:0], in_rd, OPC_LUI};
      4'd7, 4'd8: begin
        w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                 (in_op == 4'd8) ? 3'b001 : 3'b000,
                 in_imm[4:1], in_imm[11], OPC_BR};
        w_legal = ~in_imm[0];
      end
      default: w_legal = 1'b0;
    endcase
  end

  // An illegal final instruction ends the session without a halt word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        if (w_xfer) begin
          if (in_last) begin
`ifdef SR_ENC_HALT_EN
            w_state_next = (w_legal && !w_at_end) ? S_HALT : S_IDLE;
`else
            w_state_next = S_IDLE;
`endif
          end else if (w_legal && w_at_end) begin
            w_state_next = S_IDLE;
          end
        end
      end
`ifdef SR_ENC_HALT_EN
      S_HALT: w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_count        <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_fin          <= 1'b0;
      r_done         <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_we    <= 1'b0;
      r_fin   <= 1'b0;
      r_done  <= r_fin;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr          <= base_addr;
            r_count        <= '0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr;
              r_wdata <= w_enc;
              r_count <= r_count + (AW+1)'(1);
              if (!w_at_end) r_ptr <= r_ptr + AW'(1);
              if (in_last) begin
`ifdef SR_ENC_HALT_EN
                if (w_at_end) begin
                  r_err_overflow <= 1'b1;
                  r_fin          <= 1'b1;
                end
`else
                r_fin <= 1'b1;
`endif
              end else if (w_at_end) begin
                r_err_overflow <= 1'b1;
                r_fin          <= 1'b1;
              end
            end else begin
              // No write to wait for, so done follows the accept directly.
              r_err_illegal <= 1'b1;
              if (in_last) r_done <= 1'b1;
            end
          end
        end
`ifdef SR_ENC_HALT_EN
        S_HALT: begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= 32'h0000_0063;
          r_count <= r_count + (AW+1)'(1);
          if (!w_at_end) r_ptr <= r_ptr + AW'(1);
          r_fin   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_instr_encoder.sv
// Directed bench for sr_instr_encoder: a default-width instance plus an AW=2 instance for overflow.
module tb_sr_instr_encoder;
  localparam int AW  = 6;
  localparam int AW2 = 2;
`ifdef SR_ENC_HALT_EN
  localparam int HALT = 1;
`else
  localparam int HALT = 0;
`endif
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd4, OP_ADDI = 4'd5,
                         OP_LUI = 4'd6, OP_BEQ = 4'd7, OP_BNE = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW2-1:0] base2 = '0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [19:0] in_imm = '0;

  logic          in_ready, im_we, busy, done, err_illegal, err_overflow;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;

  logic           in_ready2, im_we2, busy2, done2, err_illegal2, err_overflow2;
  logic [AW2-1:0] im_addr2;
  logic [31:0]    im_wdata2;
  logic [AW2:0]   count2;

  sr_instr_encoder #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .count(count), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  sr_instr_encoder #(.AW(AW2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2), .busy(busy2),
    .done(done2), .count(count2), .err_illegal(err_illegal2), .err_overflow(err_overflow2)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [AW-1:0]  wa_q[$];
  logic [31:0]    wd_q[$];
  int             wc_q[$];
  int             done_cnt = 0;
  logic [AW2-1:0] wa2_q[$];
  logic [31:0]    wd2_q[$];
  int             done2_cnt = 0;

  // Write/done monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (im_we) begin
      wa_q.push_back(im_addr); wd_q.push_back(im_wdata); wc_q.push_back(cyc);
    end
    if (done) done_cnt++;
    if (im_we2) begin
      wa2_q.push_back(im_addr2); wd2_q.push_back(im_wdata2);
    end
    if (done2) done2_cnt++;
  end

  task automatic start_session(input logic [AW-1:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); done_cnt = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [19:0] imm, input logic last);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_and_drain();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({im_we, busy, done, in_ready, err_illegal, err_overflow} !== 6'b0 ||
        count !== '0 || im_addr !== '0 || im_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b busy=%b done=%b rdy=%b ei=%b eo=%b cnt=%0d addr=%0d data=%h want all 0",
               im_we, busy, done, in_ready, err_illegal, err_overflow, count, im_addr, im_wdata);
    end
    vectors++;
    if ({im_we2, busy2, in_ready2, count2} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs2 got we=%b busy=%b rdy=%b cnt=%0d want 0", im_we2, busy2, in_ready2, count2);
    end
  endtask

  task automatic test_basic();
    logic [31:0]   ed[$];
    logic [AW-1:0] ea[$];
    ed = '{32'h003100B3, 32'h00500093, 32'h12345137};
    ea = '{6'd0, 6'd1, 6'd2};
    if (HALT != 0) begin ed.push_back(32'h00000063); ea.push_back(6'd3); end
    start_session(6'd0);
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_run_state got busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 20'd5, 1'b0);
    send(OP_LUI, 5'd2, 5'd0, 5'd0, 20'h12345, 1'b1);
    idle_and_drain();
    vectors++;
    if (wd_q.size() != ed.size()) begin
      miscompares++;
      $display("FAIL basic_nwrites got %0d want %0d", wd_q.size(), ed.size());
    end else begin
      for (int i = 0; i < ed.size(); i++) begin
        vectors++;
        if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL basic_write%0d got %h@%0d want %h@%0d", i, wd_q[i], wa_q[i], ed[i], ea[i]);
        end
      end
    end
    vectors++;
    if (count !== 7'(3 + HALT) || done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end got cnt=%0d done=%0d busy=%b want cnt=%0d done=1 busy=0",
               count, done_cnt, busy, 3 + HALT);
    end
  endtask

  task automatic test_illegal();
    start_session(6'd30);
    send(4'd12, 5'd1, 5'd1, 5'd1, 20'd0, 1'b0);
    vectors++;
    if (err_illegal !== 1'b1 || count !== '0) begin
      miscompares++;
      $display("FAIL illegal_op got ei=%b cnt=%0d want ei=1 cnt=0", err_illegal, count);
    end
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 20'd3, 1'b1);
    idle_and_drain();
    vectors++;
    if (wd_q.size() != 0 || count !== '0 || err_illegal !== 1'b1 || done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_end got writes=%0d cnt=%0d ei=%b done=%0d busy=%b want 0 0 1 1 0",
               wd_q.size(), count, err_illegal, done_cnt, busy);
    end
  endtask

  task automatic test_sub_bne();
    start_session(6'd10);
    vectors++;
    if (err_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL sticky_clear got ei=%b want 0", err_illegal);
    end
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 20'd0, 1'b0);
    send(OP_BNE, 5'd0, 5'd1, 5'd2, 20'h1FFFC, 1'b1);
    idle_and_drain();
    vectors++;
    if (wd_q.size() < 2) begin
      miscompares++;
      $display("FAIL subbne_nwrites got %0d want >=2", wd_q.size());
    end else begin
      vectors++;
      if (wd_q[0] !== 32'h402081B3 || wa_q[0] !== 6'd10) begin
        miscompares++;
        $display("FAIL sub_write got %h@%0d want 402081b3@10", wd_q[0], wa_q[0]);
      end
      vectors++;
      if (wd_q[1] !== 32'hFE209EE3 || wa_q[1] !== 6'd11) begin
        miscompares++;
        $display("FAIL bne_write got %h@%0d want fe209ee3@11", wd_q[1], wa_q[1]);
      end
    end
    vectors++;
    if (err_illegal !== 1'b0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL subbne_end got ei=%b done=%0d want 0 1", err_illegal, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    start_session(6'd20);
    for (int i = 0; i < 4; i++) send(OP_ADD, 5'(i + 4), 5'd0, 5'd0, 20'd0, (i == 3));
    idle_and_drain();
    vectors++;
    if (wd_q.size() != 4 + HALT) begin
      miscompares++;
      $display("FAIL b2b_nwrites got %0d want %0d", wd_q.size(), 4 + HALT);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wa_q[i] !== 6'(20 + i) || wd_q[i] !== ((32'(i + 4) << 7) | 32'h33) || wc_q[i] != wc_q[0] + i) begin
          miscompares++;
          $display("FAIL b2b_write%0d got %h@%0d cyc+%0d want %h@%0d cyc+%0d", i, wd_q[i], wa_q[i],
                   wc_q[i] - wc_q[0], (32'(i + 4) << 7) | 32'h33, 20 + i, i);
        end
      end
    end
  endtask

  task automatic test_overflow();
    start2 = 1'b1; base2 = 2'd2;
    @(negedge clk);
    start2 = 1'b0;
    wa2_q.delete(); wd2_q.delete(); done2_cnt = 0;
    send(OP_ADD, 5'd1, 5'd0, 5'd0, 20'd0, 1'b0);
    send(OP_ADD, 5'd2, 5'd0, 5'd0, 20'd0, 1'b0);
    in_op = OP_ADD; in_rd = 5'd3; in_valid = 1'b1;
    vectors++;
    if (in_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_ready got %b want 0", in_ready2);
    end
    idle_and_drain();
    vectors++;
    if (wd2_q.size() != 2) begin
      miscompares++;
      $display("FAIL ovf_nwrites got %0d want 2", wd2_q.size());
    end else begin
      vectors++;
      if (wa2_q[0] !== 2'd2 || wa2_q[1] !== 2'd3) begin
        miscompares++;
        $display("FAIL ovf_addrs got %0d,%0d want 2,3", wa2_q[0], wa2_q[1]);
      end
    end
    vectors++;
    if (err_overflow2 !== 1'b1 || count2 !== 3'd2 || done2_cnt != 1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_end got eo=%b cnt=%0d done=%0d busy=%b want 1 2 1 0",
               err_overflow2, count2, done2_cnt, busy2);
    end
  endtask

  task automatic test_reset_pending();
    start_session(6'd40);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0);
    in_valid = 1'b0;
    vectors++;
    if (im_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rstpend_write got we=%b want 1", im_we);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (im_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL rstpend_idle got we=%b busy=%b rdy=%b cnt=%0d want 0 0 0 0", im_we, busy, in_ready, count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt();
    start_session(6'd0);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 20'd0, 1'b1);
    idle_and_drain();
    vectors++;
    if (wd_q.size() != 1 + HALT || wd_q[0] !== 32'h003100B3 || wa_q[0] !== 6'd0) begin
      miscompares++;
      $display("FAIL halt_first got n=%0d %h want n=%0d 003100b3@0", wd_q.size(), wd_q[0], 1 + HALT);
    end else if (HALT != 0) begin
      vectors++;
      if (wd_q[1] !== 32'h00000063 || wa_q[1] !== 6'd1) begin
        miscompares++;
        $display("FAIL halt_word got %h@%0d want 00000063@1", wd_q[1], wa_q[1]);
      end
    end
    vectors++;
    if (count !== 7'(1 + HALT) || done_cnt != 1) begin
      miscompares++;
      $display("FAIL halt_end got cnt=%0d done=%0d want %0d 1", count, done_cnt, 1 + HALT);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_illegal();
    test_sub_bne();
    test_back_to_back();
    test_overflow();
    test_reset_pending();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sr_instr_encoder.md
Name: sr_instr_encoder

Overview:
- Inverse of the schoolRISCV control decoder.
- Accepts symbolic instructions (op code plus rd/rs1/rs2/imm fields) over a valid/ready stream.
- Encodes each one into a 32-bit RV32I word and writes it sequentially into the word-addressed instruction memory.
- Used as a program loader / self-test program generator ahead of the CPU, driven by a bench or a UART command path.

Parameters:
- AW, 6, instruction memory word-address width; capacity 2^AW words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a load session at base_addr
- base_addr  in  AW  first word address of the session
- in_valid  in  1  instruction field bundle valid
- in_ready  out  1  encoder can accept this cycle
- in_op  in  4  0 ADD, 1 OR, 2 SRL, 3 SLTU, 4 SUB, 5 ADDI, 6 LUI, 7 BEQ, 8 BNE; 9-15 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  20  ADDI: [11:0]; LUI: [19:0]; BEQ/BNE: signed byte offset [12:0]
- in_last  in  1  final instruction of the session
- im_we  out  1  instruction memory write strobe
- im_addr  out  AW  write word address
- im_wdata  out  32  encoded instruction
- busy  out  1  session active (state RUN or HALT)
- done  out  1  one-cycle pulse when the session ends
- count  out  AW+1  words written this session
- err_illegal  out  1  sticky; illegal op or odd branch offset seen
- err_overflow  out  1  sticky; memory end reached before in_last

Behaviour:
- Reset values: all outputs 0; state IDLE; address pointer 0.
- States:
  - IDLE -> RUN on start. Pointer loads base_addr; count, err_illegal and err_overflow clear.
  - RUN -> IDLE on accepting in_last (or -> HALT, see Optional Feature).
  - RUN -> IDLE on overflow.
  - start is ignored outside IDLE.
- in_ready = (state == RUN). Transfer occurs when in_valid & in_ready. Throughput is one instruction per clock.
- Latency: a transfer in cycle N gives im_we=1 in cycle N+1, with registered im_addr and im_wdata. The pointer and count increment at the same N+1 edge.
- Encoding:
  - R-type: {f7, rs2, rs1, f3, rd, 0110011}.
    - ADD f3=000 f7=0000000; OR f3=110; SRL f3=101; SLTU f3=011; SUB f3=000 f7=0100000.
  - ADDI: {imm[11:0], rs1, 000, rd, 0010011}.
  - LUI: {imm[19:0], rd, 0110111}.
  - BEQ/BNE: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}; f3 = 000 for BEQ, 001 for BNE.
  - Fields unused by an op are ignored.
- Illegal op (9-15), or branch with imm[0]=1:
  - The transfer is accepted, nothing is written, and the pointer and count hold.
  - err_illegal is set.
  - in_last on such a transfer still ends the session.
- Overflow: writing address 2^AW-1 without in_last sets err_overflow, drops in_ready the same cycle, and moves the FSM -> IDLE with a done pulse. The pointer does not wrap.
- done pulses in the cycle after the final write (or after the final accept, if that transfer was illegal).
- Reset in any state: immediate return to IDLE. A pending write is discarded, so im_we=0 in the cycle after rst.

Optional Feature:
- Macro: SR_ENC_HALT_EN.
- Defined:
  - After in_last is accepted, the FSM enters HALT and writes 0x00000063 (beq zero,zero,0, a self-loop) at the next address one cycle after the last write, then goes to IDLE with done.
  - count includes the halt word.
  - If no address remains, the halt word is skipped and err_overflow is set.
- Undefined: the HALT state is absent; the session ends after the last word.

Test Plan:
- start, base_addr=0; stream ADD rd=1 rs1=2 rs2=3, ADDI rd=1 rs1=0 imm=5, LUI rd=2 imm=0x12345 (last) -> writes 0x003100B3 @0, 0x00500093 @1, 0x12345137 @2; count=3; one done pulse.
- SUB rd=3 rs1=1 rs2=2, then BNE rs1=1 rs2=2 imm=-4 (0x1FFFC) -> 0x402081B3, 0xFE209EE3 at consecutive addresses.
- in_valid held high for 4 back-to-back ops -> 4 consecutive im_we cycles; addresses base..base+3.
- in_op=12, then BEQ imm=3 (last) -> no writes; err_illegal=1; count=0; done pulses.
- AW=2, base_addr=2, three ops with no last -> writes @2, @3; third op not accepted (in_ready=0); err_overflow=1.
- rst asserted in the cycle after a transfer -> no im_we; state IDLE. With SR_ENC_HALT_EN and a single ADD (last) at base 0 -> 0x00000063 written @1; count=2.
